// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (IF) and the
// load/store path (D). It runs one transaction at a time and gives D priority.
// A streak counter caps D wins while a fetch waits.
// A fetch that is flushed still finishes on the bus, but its result is dropped.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic if_elig, d_elig, grant_if, grant_d;

  // A requester that is completing this cycle must not be granted again straight away.
  assign if_elig = if_req & ~if_flush & ~if_done_q;
  assign d_elig  = d_req & ~d_done_q;

  // Idle arbitration: D wins unless a waiting fetch has seen the maximum streak of D grants.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE) begin
      if (if_elig && d_elig) begin
        grant_if = (streak_q == STREAK_MAX);
        grant_d  = (streak_q != STREAK_MAX);
      end else begin
        grant_if = if_elig;
        grant_d  = d_elig;
      end
    end
  end

  // Next-state logic for the bus sequencer, the streak counter and the result registers.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_done_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_done_d     = 1'b0;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d    = BUS_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = '1;
        end else if (grant_d) begin
          state_d     = BUS_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end
      end
      BUS_IF: begin
        if (if_flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (flush_pend_q || if_flush) begin
            flush_pend_d = 1'b0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      BUS_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!if_req)
      streak_d = '0;
    else if (grant_if)
      streak_d = '0;
    else if (grant_d && streak_q != STREAK_MAX)
      streak_d = streak_q + 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_done_q    <= if_done_d;
      if_rdata_q   <= if_rdata_d;
      d_done_q     <= d_done_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic.
// A transaction-level reference model runs alongside and checks every cycle.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data) plus the visible outputs.
  int          m_owner = 0;
  int          m_streak = 0;
  bit          m_fp = 0;
  bit          m_req = 0, m_we = 0, m_ifd = 0, m_dd = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ifr = '0, m_dr = '0;
  logic [3:0]  m_be = '0;

  always @(posedge clk) begin
    bit ie, de, gi, gd, finish_bus;
    if (rst) begin
      m_owner = 0; m_streak = 0; m_fp = 0; m_req = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_be = '0;
      m_ifd = 0; m_ifr = '0; m_dd = 0; m_dr = '0;
    end else begin
      ie = if_req && !if_flush && !m_ifd;
      de = d_req && !m_dd;
      gi = 0; gd = 0;
      if (m_owner == 0) begin
        if (ie && (!de || m_streak == MAXS)) gi = 1;
        else if (de) gd = 1;
      end
      m_ifd = 0; m_dd = 0;
      finish_bus = (m_owner != 0) && mem_ready;
      if (m_owner == 1) begin
        if (if_flush) m_fp = 1;
        if (finish_bus) begin
          if (m_fp) m_fp = 0;
          else begin m_ifd = 1; m_ifr = mem_rdata; end
        end
      end else if (m_owner == 2 && finish_bus) begin
        m_dd = 1;
        if (!m_we) m_dr = mem_rdata;
      end
      if (finish_bus) begin m_owner = 0; m_req = 0; m_we = 0; end
      if (gi) begin
        m_owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_be = 4'hF;
      end else if (gd) begin
        m_owner = 2; m_req = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
      end
      if (!if_req) m_streak = 0;
      else if (gi) m_streak = 0;
      else if (gd && m_streak < MAXS) m_streak = m_streak + 1;
    end
  end

  // Cycle-by-cycle comparison of every output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 1;
      if ({mem_req, mem_we, if_done, d_done} !== {m_req, m_we, m_ifd, m_dd}) begin
        errors += 1;
        $display("FAIL model_ctrl t=%0t got req/we/ifd/dd=%b%b%b%b want %b%b%b%b", $time,
                 mem_req, mem_we, if_done, d_done, m_req, m_we, m_ifd, m_dd);
      end
      checks += 1;
      if ({mem_addr, mem_wdata, mem_be} !== {m_addr, m_wdata, m_be}) begin
        errors += 1;
        $display("FAIL model_bus t=%0t got addr=%h wdata=%h be=%h want %h %h %h", $time,
                 mem_addr, mem_wdata, mem_be, m_addr, m_wdata, m_be);
      end
      checks += 1;
      if ({if_rdata, d_rdata} !== {m_ifr, m_dr}) begin
        errors += 1;
        $display("FAIL model_rdata t=%0t got if=%h d=%h want %h %h", $time,
                 if_rdata, d_rdata, m_ifr, m_dr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    checks += 1;
    if ({mem_req, mem_we, if_done, d_done, mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
      errors += 1;
      $display("FAIL reset_outputs got req=%b addr=%h ifr=%h dr=%h want all zero",
               mem_req, mem_addr, if_rdata, d_rdata);
    end
    rst = 0;
    chk_en = 1;
    idle(1);
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h100;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_be !== 4'hF) begin
      errors += 1;
      $display("FAIL fetch_bus got req=%b we=%b addr=%h be=%h want 1 0 00000100 f",
               mem_req, mem_we, mem_addr, mem_be);
    end
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    step();
    checks += 1;
    if (if_done !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_req !== 1'b0) begin
      errors += 1;
      $display("FAIL fetch_done got done=%b rdata=%h req=%b want 1 00500093 0",
               if_done, if_rdata, mem_req);
    end
    idle(1);
    checks += 1;
    if (if_done !== 1'b0) begin
      errors += 1;
      $display("FAIL fetch_pulse got done=%b want 0", if_done);
    end
    idle(1);
  endtask

  task automatic test_priority();
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
      errors += 1;
      $display("FAIL prio_d_first got req=%b addr=%h we=%b want 1 00002000 0", mem_req, mem_addr, mem_we);
    end
    step();
    mem_ready = 1; mem_rdata = 32'hA5A5_0001;
    step();
    checks += 1;
    if (d_done !== 1'b1 || d_rdata !== 32'hA5A5_0001 || mem_req !== 1'b0) begin
      errors += 1;
      $display("FAIL prio_d_done got done=%b rdata=%h req=%b want 1 a5a50001 0", d_done, d_rdata, mem_req);
    end
    d_req = 0; mem_ready = 0;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_be !== 4'hF) begin
      errors += 1;
      $display("FAIL prio_if_next got req=%b addr=%h be=%h want 1 00000040 f", mem_req, mem_addr, mem_be);
    end
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    step();
    checks += 1;
    if (if_done !== 1'b1 || if_rdata !== 32'h1234_5678) begin
      errors += 1;
      $display("FAIL prio_if_done got done=%b rdata=%h want 1 12345678", if_done, if_rdata);
    end
    idle(2);
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h3004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    step();
    for (int i = 0; i < 4; i++) begin
      checks += 1;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3004 ||
          mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b0011) begin
        errors += 1;
        $display("FAIL store_stable[%0d] got req=%b we=%b addr=%h wd=%h be=%h want 1 1 00003004 deadbeef 3",
                 i, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
      if (i < 3) step();
    end
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    step();
    checks += 1;
    if (d_done !== 1'b1 || d_rdata !== 32'hA5A5_0001 || mem_we !== 1'b0) begin
      errors += 1;
      $display("FAIL store_done got done=%b rdata=%h we=%b want 1 a5a50001 0", d_done, d_rdata, mem_we);
    end
    idle(1);
    checks += 1;
    if (d_done !== 1'b0) begin
      errors += 1;
      $display("FAIL store_pulse got done=%b want 0", d_done);
    end
    idle(1);
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 32'h700;
    step();
    step();
    if_flush = 1;
    step();
    if_flush = 0; if_req = 0; mem_ready = 1; mem_rdata = 32'hFFFF_0000;
    step();
    checks += 1;
    if (if_done !== 1'b0 || if_rdata !== 32'h1234_5678 || mem_req !== 1'b0) begin
      errors += 1;
      $display("FAIL flush_suppress got done=%b rdata=%h req=%b want 0 12345678 0", if_done, if_rdata, mem_req);
    end
    if_req = 1; if_addr = 32'h800; mem_ready = 0;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin
      errors += 1;
      $display("FAIL flush_refetch got req=%b addr=%h want 1 00000800", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    checks += 1;
    if (if_done !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
      errors += 1;
      $display("FAIL flush_refetch_done got done=%b rdata=%h want 1 0badf00d", if_done, if_rdata);
    end
    idle(2);
  endtask

  task automatic test_starvation();
    if_req = 1; if_flush = 1; if_addr = 32'h600;
    d_req = 1; d_we = 0; d_addr = 32'h500;
    for (int n = 0; n < MAXS; n++) begin
      step();
      checks += 1;
      if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
        errors += 1;
        $display("FAIL starve_d[%0d] got req=%b addr=%h want 1 00000500", n, mem_req, mem_addr);
      end
      mem_ready = 1; mem_rdata = 32'hD000_0000 + n;
      step();
      mem_ready = 0;
      step();
    end
    if_flush = 0;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
      errors += 1;
      $display("FAIL starve_if_wins got req=%b addr=%h want 1 00000600", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'hC0DE_0001;
    step();
    if_req = 0; mem_ready = 0;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
      errors += 1;
      $display("FAIL starve_d_again got req=%b addr=%h want 1 00000500", mem_req, mem_addr);
    end
    mem_ready = 1;
    step();
    idle(2);
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 32'h900;
    step();
    checks += 1;
    if (mem_req !== 1'b1) begin
      errors += 1;
      $display("FAIL rstmid_bus got req=%b want 1", mem_req);
    end
    rst = 1;
    step();
    checks += 1;
    if (mem_req !== 1'b0 || d_done !== 1'b0 || mem_addr !== '0 || if_rdata !== '0) begin
      errors += 1;
      $display("FAIL rstmid_clear got req=%b done=%b addr=%h ifr=%h want 0 0 0 0", mem_req, d_done, mem_addr, if_rdata);
    end
    rst = 0;
    step();
    checks += 1;
    if (mem_req !== 1'b1 || mem_addr !== 32'h900 || d_done !== 1'b0) begin
      errors += 1;
      $display("FAIL rstmid_regrant got req=%b addr=%h done=%b want 1 00000900 0", mem_req, mem_addr, d_done);
    end
    mem_ready = 1; mem_rdata = 32'h77;
    step();
    checks += 1;
    if (d_done !== 1'b1 || d_rdata !== 32'h77) begin
      errors += 1;
      $display("FAIL rstmid_done got done=%b rdata=%h want 1 00000077", d_done, d_rdata);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(199) == 0);
      if_req    = ($urandom_range(9) < 7);
      if_flush  = ($urandom_range(9) == 0);
      if_addr   = $urandom;
      d_req     = ($urandom_range(9) < 6);
      d_we      = $urandom_range(1);
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_be      = 4'($urandom_range(15));
      mem_ready = ($urandom_range(9) < 4);
      mem_rdata = $urandom;
      step();
    end
    rst = 0;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_flush();
    test_starvation();
    test_reset_mid();
    test_random();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
